// File: rtl/wm8731_i2c_config.sv
// WM8731 power-up configuration sequencer: walks a fixed register table and issues each
// entry as a 3-byte I2C write, retrying an entry on NACK up to MAX_RETRY times.
module wm8731_i2c_config #(
    parameter int unsigned CLK_DIV    = 125,
    parameter logic [6:0]  DEV_ADDR   = 7'h1A,
    parameter int unsigned NUM_REGS   = 10,
    parameter int unsigned MAX_RETRY  = 3,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       start,
    output logic       i2c_sclk,
    output logic       i2c_sdat_oe,
    input  logic       i2c_sdat_in,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] reg_idx
);

    localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [DivW-1:0]   DivLast  = DivW'(CLK_DIV - 1);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
    localparam logic [3:0]        IdxLast  = 4'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StBit, StAck, StStop, StGap, StDone, StError
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [3:0]        idx_q, idx_d;
    logic              nack_q, nack_d;
    logic              sclk_q, sclk_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              auto_q, auto_d;

    logic        tick;
    logic [15:0] entry;
    logic [7:0]  cur_byte;

    // Table entry layout: {7-bit register address, 9-bit register data}.
    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    return {7'd15, 9'h000};
            4'd1:    return {7'd0,  9'h017};
            4'd2:    return {7'd1,  9'h017};
            4'd3:    return {7'd2,  9'h079};
            4'd4:    return {7'd3,  9'h079};
            4'd5:    return {7'd4,  9'h012};
            4'd6:    return {7'd5,  9'h000};
            4'd7:    return {7'd6,  9'h000};
            4'd8:    return {7'd7,  9'h042};
            4'd9:    return {7'd8,  9'h000};
            default: return 16'h0000;
        endcase
    endfunction

    assign tick  = busy_q && (div_q == DivLast);
    assign entry = table_entry(idx_q);

    always_comb begin
        case (byte_q)
            2'd0:    cur_byte = {DEV_ADDR, 1'b0};
            2'd1:    cur_byte = entry[15:8];
            default: cur_byte = entry[7:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        retry_d = retry_q;
        idx_d   = idx_q;
        nack_d  = nack_q;
        sclk_d  = sclk_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
        auto_d  = auto_q;
        div_d   = '0;
        if (busy_q) begin
            div_d = tick ? '0 : div_q + DivW'(1);
        end

        case (state_q)
            StIdle, StDone, StError: begin
                sclk_d  = 1'b1;
                oe_d    = 1'b0;
                state_d = StIdle;
                if (start || auto_q) begin
                    state_d = StStart;
                    phase_d = 2'd0;
                    idx_d   = 4'd0;
                    retry_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    auto_d  = 1'b0;
                end
            end
            StStart: if (tick) begin
                phase_d = phase_q + 2'd1;
                case (phase_q)
                    2'd0: begin
                        oe_d   = 1'b0;
                        sclk_d = 1'b1;
                    end
                    2'd1: oe_d = 1'b1;
                    default: begin
                        sclk_d  = 1'b0;
                        state_d = StBit;
                        phase_d = 2'd0;
                        bit_d   = 3'd7;
                        byte_d  = 2'd0;
                        nack_d  = 1'b0;
                    end
                endcase
            end
            StBit: if (tick) begin
                phase_d = phase_q + 2'd1;
                case (phase_q)
                    2'd0:    oe_d   = ~cur_byte[bit_q];
                    2'd1:    sclk_d = 1'b1;
                    2'd2:    ;
                    default: begin
                        sclk_d = 1'b0;
                        if (bit_q == 3'd0) begin
                            state_d = StAck;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                endcase
            end
            StAck: if (tick) begin
                phase_d = phase_q + 2'd1;
                case (phase_q)
                    2'd0:    oe_d   = 1'b0;
                    2'd1:    sclk_d = 1'b1;
                    2'd2:    nack_d = i2c_sdat_in;
                    default: begin
                        sclk_d = 1'b0;
                        if (nack_q || byte_q == 2'd2) begin
                            state_d = StStop;
                        end else begin
                            byte_d  = byte_q + 2'd1;
                            bit_d   = 3'd7;
                            state_d = StBit;
                        end
                    end
                endcase
            end
            StStop: if (tick) begin
                phase_d = phase_q + 2'd1;
                case (phase_q)
                    2'd0: begin
                        oe_d   = 1'b1;
                        sclk_d = 1'b0;
                    end
                    2'd1: sclk_d = 1'b1;
                    default: begin
                        oe_d    = 1'b0;
                        state_d = StGap;
                        phase_d = 2'd0;
                    end
                endcase
            end
            StGap: if (tick) begin
                phase_d = phase_q + 2'd1;
                // Bus free time elapsed: decide retry, advance, or finish.
                if (phase_q == 2'd3) begin
                    phase_d = 2'd0;
                    if (nack_q) begin
                        if (retry_q < RetryMax) begin
                            retry_d = retry_q + RetryW'(1);
                            state_d = StStart;
                        end else begin
                            state_d = StError;
                            busy_d  = 1'b0;
                            error_d = 1'b1;
                        end
                    end else if (idx_q < IdxLast) begin
                        idx_d   = idx_q + 4'd1;
                        retry_d = '0;
                        state_d = StStart;
                    end else begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            phase_q <= 2'd0;
            div_q   <= '0;
            bit_q   <= 3'd7;
            byte_q  <= 2'd0;
            retry_q <= '0;
            idx_q   <= 4'd0;
            nack_q  <= 1'b0;
            sclk_q  <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            auto_q  <= AUTO_START;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            retry_q <= retry_d;
            idx_q   <= idx_d;
            nack_q  <= nack_d;
            sclk_q  <= sclk_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            auto_q  <= auto_d;
        end
    end

    assign i2c_sclk    = sclk_q;
    assign i2c_sdat_oe = oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign reg_idx     = idx_q;

endmodule

// File: tb/tb_wm8731_i2c_config.sv
// Directed bench for wm8731_i2c_config: an I2C slave model decodes frames on the bus,
// injects NACKs on demand, and records timing of SCL edges and START/STOP conditions.
module tb_wm8731_i2c_config;

    localparam int DIV   = 5;
    localparam int LIMIT = 20000;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b1;
    logic       start    = 1'b0;
    logic       i2c_sclk;
    logic       i2c_sdat_oe;
    logic       i2c_sdat_in;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] reg_idx;

    logic slv_pull = 1'b0;
    logic sda_line;

    assign sda_line    = ~(i2c_sdat_oe | slv_pull);
    assign i2c_sdat_in = sda_line;

    always #5 CLOCK_50 = ~CLOCK_50;

    wm8731_i2c_config #(
        .CLK_DIV    (DIV),
        .DEV_ADDR   (7'h1A),
        .NUM_REGS   (10),
        .MAX_RETRY  (3),
        .AUTO_START (1'b1)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .start       (start),
        .i2c_sclk    (i2c_sclk),
        .i2c_sdat_oe (i2c_sdat_oe),
        .i2c_sdat_in (i2c_sdat_in),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .reg_idx     (reg_idx)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model state and frame log.
    logic [23:0] fr_data   [0:63];
    int          fr_n      [0:63];
    int          fr_tstart [0:63];
    int          fr_tstop  [0:63];
    int          fr_cnt    = 0;
    int          per_min   = 1000000;
    int          per_max   = 0;
    int          cond_min  = 1000000;
    int          nack_mode = 0;
    int          nack_base = 0;

    initial begin
        int          cyc = 0;
        logic        p_scl = 1'b1;
        logic        p_sda = 1'b1;
        logic        in_frame = 1'b0;
        logic        ack_ph = 1'b0;
        int          bitn = 0;
        int          byten = 0;
        int          cur_n = 0;
        logic [23:0] cur_data = '0;
        logic [7:0]  sh = '0;
        int          last_rise = -1;
        int          last_scl_edge = -1000000;
        int          last_cond = -1000000;
        int          rel;
        logic        nack_now;
        forever begin
            @(negedge CLOCK_50);
            cyc++;
            if (i2c_sclk && p_scl && p_sda && !sda_line) begin
                in_frame = 1'b1; ack_ph = 1'b0; bitn = 0; byten = 0; cur_n = 0;
                cur_data = '0; last_rise = -1;
                if (fr_cnt < 64) fr_tstart[fr_cnt] = cyc;
                if (cyc - last_scl_edge < cond_min) cond_min = cyc - last_scl_edge;
                last_cond = cyc;
            end else if (i2c_sclk && p_scl && !p_sda && sda_line) begin
                if (in_frame && fr_cnt < 64) begin
                    fr_data[fr_cnt]  = cur_data;
                    fr_n[fr_cnt]     = cur_n;
                    fr_tstop[fr_cnt] = cyc;
                    fr_cnt++;
                end
                in_frame = 1'b0;
                if (cyc - last_scl_edge < cond_min) cond_min = cyc - last_scl_edge;
                last_cond = cyc;
            end
            if (i2c_sclk && !p_scl) begin
                if (cyc - last_cond < cond_min) cond_min = cyc - last_cond;
                last_scl_edge = cyc;
                if (in_frame) begin
                    if (last_rise >= 0) begin
                        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
                        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
                    end
                    last_rise = cyc;
                    if (bitn < 8) begin
                        sh = {sh[6:0], sda_line};
                        bitn++;
                    end
                end
            end
            if (!i2c_sclk && p_scl) begin
                if (cyc - last_cond < cond_min) cond_min = cyc - last_cond;
                last_scl_edge = cyc;
                if (in_frame) begin
                    if (ack_ph) begin
                        slv_pull = 1'b0; ack_ph = 1'b0; bitn = 0; byten++;
                    end else if (bitn == 8) begin
                        if (byten < 3) cur_data[23 - 8*byten -: 8] = sh;
                        cur_n = byten + 1;
                        rel = fr_cnt - nack_base;
                        nack_now = (byten == 0) &&
                                   ((nack_mode == 2) || (nack_mode == 1 && (rel == 3 || rel == 4)));
                        slv_pull = !nack_now;
                        ack_ph   = 1'b1;
                    end
                end
            end
            p_scl = i2c_sclk;
            p_sda = sda_line;
        end
    end

    logic [23:0] exp_fr [10] = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
                                 24'h340812, 24'h340A00, 24'h340C00, 24'h340E42, 24'h341000};

    task automatic pulse_start();
        @(negedge CLOCK_50);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        repeat (3) @(negedge CLOCK_50);
        while (!(!busy && (done || error)) && n < LIMIT) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= LIMIT) check_eq({tag, "_timeout"}, 32'(n), 32'd0);
        #1;
    endtask

    task automatic check_frame(input string tag, input int idx, input logic [23:0] exp);
        check_eq($sformatf("%s_data%0d", tag, idx), {8'h0, fr_data[idx]}, {8'h0, exp});
        check_eq($sformatf("%s_nbytes%0d", tag, idx), 32'(fr_n[idx]), 32'd3);
    endtask

    initial begin
        int base;
        int n;
        #2 RESET_N = 1'b0;
        #1;
        check_eq("rst_sclk", {31'b0, i2c_sclk}, 32'd1);
        check_eq("rst_oe", {31'b0, i2c_sdat_oe}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_error", {31'b0, error}, 32'd0);
        check_eq("rst_idx", {28'b0, reg_idx}, 32'd0);
        repeat (3) @(negedge CLOCK_50);

        // Auto-started full run, slave always ACKs.
        base = fr_cnt;
        RESET_N = 1'b1;
        wait_idle("run1");
        check_eq("run1_done", {31'b0, done}, 32'd1);
        check_eq("run1_busy", {31'b0, busy}, 32'd0);
        check_eq("run1_error", {31'b0, error}, 32'd0);
        check_eq("run1_idx", {28'b0, reg_idx}, 32'd9);
        check_eq("run1_frames", 32'(fr_cnt - base), 32'd10);
        for (int k = 0; k < 10; k++) check_frame("run1", base + k, exp_fr[k]);
        check_eq("scl_period_min", 32'(per_min), 32'(4 * DIV));
        check_eq("scl_period_max", 32'(per_max), 32'(4 * DIV));
        check_eq("cond_to_scl_edge", 32'(cond_min), 32'(DIV));
        for (int k = 1; k < 10; k++)
            check_eq($sformatf("run1_gap%0d", k),
                     32'(fr_tstart[base + k] - fr_tstop[base + k - 1]), 32'(6 * DIV));

        // Explicit start, then a second start while busy must be ignored.
        base = fr_cnt;
        pulse_start();
        repeat (400) @(negedge CLOCK_50);
        check_eq("run2_busy_mid", {31'b0, busy}, 32'd1);
        check_eq("run2_done_cleared", {31'b0, done}, 32'd0);
        pulse_start();
        wait_idle("run2");
        check_eq("run2_frames", 32'(fr_cnt - base), 32'd10);
        check_eq("run2_done", {31'b0, done}, 32'd1);
        check_frame("run2", base, exp_fr[0]);
        check_frame("run2", base + 9, exp_fr[9]);

        // Index 3 NACKed twice, then ACKed.
        nack_base = fr_cnt;
        nack_mode = 1;
        base = fr_cnt;
        pulse_start();
        wait_idle("run3");
        check_eq("run3_frames", 32'(fr_cnt - base), 32'd12);
        check_eq("run3_nack1_len", 32'(fr_n[base + 3]), 32'd1);
        check_eq("run3_nack2_len", 32'(fr_n[base + 4]), 32'd1);
        check_eq("run3_nack_addr", {8'h0, fr_data[base + 3]}, 32'h340000);
        check_frame("run3", base + 5, exp_fr[3]);
        check_frame("run3", base + 11, exp_fr[9]);
        check_eq("run3_retry_gap", 32'(fr_tstart[base + 4] - fr_tstop[base + 3]), 32'(6 * DIV));
        check_eq("run3_done", {31'b0, done}, 32'd1);
        check_eq("run3_error", {31'b0, error}, 32'd0);

        // Address byte always NACKed: error after MAX_RETRY+1 attempts.
        nack_mode = 2;
        base = fr_cnt;
        pulse_start();
        wait_idle("run4");
        check_eq("run4_frames", 32'(fr_cnt - base), 32'd4);
        check_eq("run4_len_last", 32'(fr_n[base + 3]), 32'd1);
        check_eq("run4_error", {31'b0, error}, 32'd1);
        check_eq("run4_done", {31'b0, done}, 32'd0);
        check_eq("run4_idx", {28'b0, reg_idx}, 32'd0);
        check_eq("run4_busy", {31'b0, busy}, 32'd0);

        // Reset mid-byte at index 5; sequence restarts from index 0.
        nack_mode = 0;
        pulse_start();
        check_eq("run5_error_cleared", {31'b0, error}, 32'd0);
        n = 0;
        while (reg_idx != 4'd5 && n < LIMIT) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= LIMIT) check_eq("run5_idx5_timeout", 32'(n), 32'd0);
        repeat (60) @(negedge CLOCK_50);
        #2 RESET_N = 1'b0;
        #1;
        check_eq("midrst_sclk", {31'b0, i2c_sclk}, 32'd1);
        check_eq("midrst_oe", {31'b0, i2c_sdat_oe}, 32'd0);
        check_eq("midrst_busy", {31'b0, busy}, 32'd0);
        check_eq("midrst_idx", {28'b0, reg_idx}, 32'd0);
        repeat (3) @(negedge CLOCK_50);
        base = fr_cnt;
        RESET_N = 1'b1;
        wait_idle("run5");
        check_eq("run5_frames", 32'(fr_cnt - base), 32'd10);
        check_frame("run5", base, exp_fr[0]);
        check_eq("run5_done", {31'b0, done}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
